// File: rtl/level_selector_stream_if.sv
// Cost stream handshake between the per-level RD cost generator and the level selector.
interface level_selector_stream_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned COST_W = 32
);
  logic                      cost_valid;
  logic                      cost_ready;
  logic [LANES*COST_W-1:0]   cost_data;

  // Cost generator side
  modport master (
    output cost_valid,
    output cost_data,
    input  cost_ready
  );

  // Level selector side
  modport slave (
    input  cost_valid,
    input  cost_data,
    output cost_ready
  );
endinterface

// File: rtl/level_selector_stream.sv
// RDOQ level selector: streams LANES candidate costs per beat and tracks the
// best (minimum) cost, its level and the runner-up cost.
module level_selector_stream #(
  parameter int unsigned COST_W    = 32,
  parameter int unsigned LVL_W     = 8,
  parameter int unsigned MAX_LEVEL = 32,
  parameter int unsigned LANES     = 2,
  parameter bit          TIE_HIGH  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LVL_W-1:0]         max_level,
  output logic                     busy,
  level_selector_stream_if.slave   cost_if,
  output logic                     done,
  output logic [LVL_W-1:0]         best_level,
  output logic [COST_W-1:0]        best_cost,
  output logic [COST_W-1:0]        second_cost
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LVL_W:0] LIM_MAX   = (LVL_W+1)'(MAX_LEVEL - 1);
  localparam logic [LVL_W:0] LANES_EXT = (LVL_W+1)'(LANES);
  localparam logic [LVL_W:0] LAST_OFS  = (LVL_W+1)'(LANES - 1);

  state_t              state_q, state_d;
  logic [LVL_W-1:0]    lim_q, lim_d;
  logic [LVL_W:0]      base_q, base_d;
  logic [COST_W-1:0]   min_q, min_d;
  logic [COST_W-1:0]   min2_q, min2_d;
  logic [LVL_W-1:0]    min_lvl_q, min_lvl_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [LVL_W-1:0]    best_level_q, best_level_d;
  logic [COST_W-1:0]   best_cost_q, best_cost_d;
  logic [COST_W-1:0]   second_cost_q, second_cost_d;

  // Merge result of the current beat with the running pair
  logic [COST_W-1:0]   mrg_min, mrg_min2;
  logic [LVL_W-1:0]    mrg_lvl;
  logic [LVL_W:0]      lane_lvl;
  logic [COST_W-1:0]   lane_cost;
  logic                beat_acc;
  logic                last_beat;
  logic [LVL_W-1:0]    lim_start;

  assign cost_if.cost_ready = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_level  = best_level_q;
  assign best_cost   = best_cost_q;
  assign second_cost = second_cost_q;

  assign beat_acc  = cost_if.cost_valid && ready_q;
  assign last_beat = (base_q + LAST_OFS) >= {1'b0, lim_q};
  assign lim_start = ({1'b0, max_level} > LIM_MAX) ? LIM_MAX[LVL_W-1:0] : max_level;

  // Lanes are visited in ascending level after the running minimum, which
  // always belongs to a lower level, so the tie rule holds across the merge.
  always_comb begin
    mrg_min   = min_q;
    mrg_min2  = min2_q;
    mrg_lvl   = min_lvl_q;
    lane_lvl  = '0;
    lane_cost = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_lvl  = base_q + (LVL_W+1)'(i);
      lane_cost = cost_if.cost_data[i*COST_W +: COST_W];
      if (lane_lvl <= {1'b0, lim_q}) begin
        if (TIE_HIGH ? (lane_cost <= mrg_min) : (lane_cost < mrg_min)) begin
          mrg_min2 = mrg_min;
          mrg_min  = lane_cost;
          mrg_lvl  = lane_lvl[LVL_W-1:0];
        end else if (TIE_HIGH ? (lane_cost <= mrg_min2) : (lane_cost < mrg_min2)) begin
          mrg_min2 = lane_cost;
        end
      end
    end
  end

  // Next-state and next-output computation for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d       = state_q;
    lim_d         = lim_q;
    base_d        = base_q;
    min_d         = min_q;
    min2_d        = min2_q;
    min_lvl_d     = min_lvl_q;
    busy_d        = busy_q;
    ready_d       = ready_q;
    done_d        = 1'b0;
    best_level_d  = best_level_q;
    best_cost_d   = best_cost_q;
    second_cost_d = second_cost_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lim_d     = lim_start;
          base_d    = '0;
          min_d     = '1;
          min2_d    = '1;
          min_lvl_d = '0;
          busy_d    = 1'b1;
          ready_d   = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_acc) begin
          base_d    = base_q + LANES_EXT;
          min_d     = mrg_min;
          min2_d    = mrg_min2;
          min_lvl_d = mrg_lvl;
          if (last_beat) begin
            ready_d       = 1'b0;
            done_d        = 1'b1;
            best_level_d  = mrg_lvl;
            best_cost_d   = mrg_min;
            second_cost_d = mrg_min2;
            state_d       = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any selection in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lim_q         <= '0;
      base_q        <= '0;
      min_q         <= '1;
      min2_q        <= '1;
      min_lvl_q     <= '0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      best_level_q  <= '0;
      best_cost_q   <= '0;
      second_cost_q <= '1;
    end else begin
      state_q       <= state_d;
      lim_q         <= lim_d;
      base_q        <= base_d;
      min_q         <= min_d;
      min2_q        <= min2_d;
      min_lvl_q     <= min_lvl_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      best_level_q  <= best_level_d;
      best_cost_q   <= best_cost_d;
      second_cost_q <= second_cost_d;
    end
  end

endmodule
